// File: rtl/mdu_iter_pkg.sv
// +----------------------------------------------------------------------------
// | mdu_iter_pkg : shared decoder op codes, MDU state encoding and constants
// | Revision     : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package mdu_iter_pkg;

  localparam int SEL_DIV_WIDTH = 4;

  localparam logic [SEL_DIV_WIDTH-1:0] SEL_NONE  = 4'd0;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_MUL   = 4'd1;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_DIV   = 4'd2;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_DIVU  = 4'd3;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_REM   = 4'd4;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_REMU  = 4'd5;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_MULW  = 4'd6;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_DIVW  = 4'd7;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_DIVUW = 4'd8;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_REMW  = 4'd9;
  localparam logic [SEL_DIV_WIDTH-1:0] SEL_REMUW = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  localparam logic [63:0] XLEN_MIN = 64'h8000_0000_0000_0000;
  localparam logic [31:0] W_MIN    = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/mdu_div_core.sv
// +----------------------------------------------------------------------------
// | mdu_div_core : restoring-division remainder/quotient shift register
// | Revision     : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mdu_div_core #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, divisor_q;
  logic [XLEN:0]   w_shift, w_diff;

  // Dividend bits leave quot MSB-first while quotient bits enter at the LSB.
  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    w_shift = '0;
    w_diff  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_shift = {rem_d, quot_d[XLEN-1]};
      w_diff  = w_shift - {1'b0, divisor_q};
      quot_d  = {quot_d[XLEN-2:0], 1'b0};
      if (w_shift >= {1'b0, divisor_q}) begin
        rem_d     = w_diff[XLEN-1:0];
        quot_d[0] = 1'b1;
      end else begin
        rem_d = w_shift[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
    end else if (start_i) begin
      rem_q     <= '0;
      quot_q    <= dividend_i;
      divisor_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// +----------------------------------------------------------------------------
// | mdu_iter : iterative RV64 M-extension multiply/divide unit
// | Optional : MDU_FAST_MUL_EN selects a single-cycle multiplier for MUL/MULW
// | Revision : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [SEL_DIV_WIDTH-1:0] op,
  input  logic [XLEN-1:0]          src_a,
  input  logic [XLEN-1:0]          src_b,
  input  logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic [XLEN-1:0]          result
);

  localparam int              HALF        = XLEN / 2;
  localparam int              CNT_W       = 7;
  localparam logic [CNT_W-1:0] C_LAST_FULL = CNT_W'(XLEN / BITS_PER_CYCLE - 1);
  localparam logic [CNT_W-1:0] C_LAST_W    = CNT_W'(HALF / BITS_PER_CYCLE - 1);

  function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_w_q, is_div_q, is_rem_q, neg_q_q, neg_r_q;
  logic [XLEN-1:0]  acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q;

  logic             w_is_w, w_is_div, w_is_rem, w_is_signed;
  logic             w_a_neg, w_b_neg, w_accept, w_special, w_fast;
  logic [XLEN-1:0]  w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_dividend;
  logic [XLEN-1:0]  w_spec_raw, w_spec_res, w_acc_init;
  logic [XLEN-1:0]  w_quot, w_rem, w_q_fix, w_r_fix, w_raw, w_fix_res;

  assign w_is_w      = op inside {SEL_MULW, SEL_DIVW, SEL_DIVUW, SEL_REMW, SEL_REMUW};
  assign w_is_div    = op inside {SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU,
                                  SEL_DIVW, SEL_DIVUW, SEL_REMW, SEL_REMUW};
  assign w_is_rem    = op inside {SEL_REM, SEL_REMU, SEL_REMW, SEL_REMUW};
  assign w_is_signed = op inside {SEL_DIV, SEL_REM, SEL_DIVW, SEL_REMW};

  // W dividends sit in the upper half so only HALF iterations are needed.
  always_comb begin
    if (w_is_w) begin
      w_a_ext = w_is_signed ? sext_w(src_a[HALF-1:0]) : {{HALF{1'b0}}, src_a[HALF-1:0]};
      w_b_ext = w_is_signed ? sext_w(src_b[HALF-1:0]) : {{HALF{1'b0}}, src_b[HALF-1:0]};
    end else begin
      w_a_ext = src_a;
      w_b_ext = src_b;
    end
    w_a_neg    = w_is_signed & w_a_ext[XLEN-1];
    w_b_neg    = w_is_signed & w_b_ext[XLEN-1];
    w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
    w_dividend = w_is_w ? (w_a_mag << HALF) : w_a_mag;

    w_special  = 1'b0;
    w_spec_raw = '0;
    if (w_is_div && (w_b_ext == '0)) begin
      w_special  = 1'b1;
      w_spec_raw = w_is_rem ? w_a_ext : '1;
    end else if (w_is_div && w_is_signed && (w_b_ext == '1) &&
                 (w_a_ext == (w_is_w ? sext_w(W_MIN) : XLEN_MIN))) begin
      w_special  = 1'b1;
      w_spec_raw = w_is_rem ? '0 : w_a_ext;
    end
    w_spec_res = w_is_w ? sext_w(w_spec_raw[HALF-1:0]) : w_spec_raw;
  end

`ifdef MDU_FAST_MUL_EN
  assign w_fast     = !w_is_div;
  assign w_acc_init = src_a * src_b;
`else
  assign w_fast     = 1'b0;
  assign w_acc_init = '0;
`endif

  assign w_accept = valid_in && (op != SEL_NONE) && (state_q == S_IDLE) && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (w_accept) begin
        if (w_special)   state_d = S_DONE;
        else if (w_fast) state_d = S_FIX;
        else begin
          state_d = S_CALC;
          cnt_d   = w_is_w ? C_LAST_W : C_LAST_FULL;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_d[0]) acc_d = acc_d + mcand_d;
      mcand_d  = mcand_d << 1;
      mplier_d = mplier_d >> 1;
    end
  end

  mdu_div_core #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_div_core (
    .clk        (clk),
    .reset      (reset),
    .start_i    (w_accept),
    .step_i     ((state_q == S_CALC) && is_div_q),
    .dividend_i (w_dividend),
    .divisor_i  (w_b_mag),
    .quot_o     (w_quot),
    .rem_o      (w_rem)
  );

  always_comb begin
    w_q_fix   = neg_q_q ? -w_quot : w_quot;
    w_r_fix   = neg_r_q ? -w_rem : w_rem;
    w_raw     = is_div_q ? (is_rem_q ? w_r_fix : w_q_fix) : acc_q;
    w_fix_res = is_w_q ? sext_w(w_raw[HALF-1:0]) : w_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_w_q   <= 1'b0;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        is_w_q   <= w_is_w;
        is_div_q <= w_is_div;
        is_rem_q <= w_is_rem;
        neg_q_q  <= w_a_neg ^ w_b_neg;
        neg_r_q  <= w_a_neg;
        acc_q    <= w_acc_init;
        mcand_q  <= w_a_ext;
        mplier_q <= w_b_ext;
      end else if ((state_q == S_CALC) && !is_div_q) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
      end
      if (w_accept && w_special)
        result_q <= w_spec_res;
      else if ((state_q == S_FIX) && !flush)
        result_q <= w_fix_res;
    end
  end

  assign busy   = (state_q != S_IDLE) || w_accept;
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// +----------------------------------------------------------------------------
// | tb_mdu_iter : directed self-checking bench for mdu_iter
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int DIV_LAT  = 66;
  localparam int DIVW_LAT = 34;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT  = 2;
  localparam int MULW_LAT = 2;
`else
  localparam int MUL_LAT  = 66;
  localparam int MULW_LAT = 34;
`endif

  logic                     clk = 1'b0;
  logic                     reset, valid_in, flush;
  logic [SEL_DIV_WIDTH-1:0] op;
  logic [63:0]              src_a, src_b;
  logic                     busy, done;
  logic [63:0]              result;

  int checks   = 0;
  int failures = 0;

  mdu_iter #(.XLEN(64), .BITS_PER_CYCLE(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [SEL_DIV_WIDTH-1:0] o,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int   k;
    logic busy_ok;
    valid_in = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    #1;
    check({tag, ".busy_accept"}, 64'(busy), 64'd1);
    tick();
    valid_in = 1'b0;
    op       = SEL_NONE;
    src_a    = '0;
    src_b    = '0;
    k        = 1;
    busy_ok  = 1'b1;
    while (!done && k < 200) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      k++;
    end
    check({tag, ".latency"}, 64'(k), 64'(lat));
    check({tag, ".busy_hold"}, 64'(busy_ok & busy), 64'd1);
    check({tag, ".result"}, result, exp);
    tick();
    check({tag, ".done_pulse"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    logic done_seen;
    reset    = 1'b1;
    valid_in = 1'b0;
    flush    = 1'b0;
    op       = SEL_NONE;
    src_a    = '0;
    src_b    = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.result", result, 64'd0);

    run_op("div_neg", SEL_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
    run_op("remu_by0", SEL_REMU, 64'd100, 64'd0, 64'd100, 1);
    run_op("divu_by0", SEL_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("div_ovf", SEL_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", SEL_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run_op("divw_ovf", SEL_DIVW, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("mulw", SEL_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT);
    run_op("mul", SEL_MUL, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, MUL_LAT);
    run_op("rem_neg", SEL_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
    run_op("divuw", SEL_DIVUW, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, DIVW_LAT);
    run_op("remw_neg", SEL_REMW, 64'h0000_0000_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, DIVW_LAT);

    // Flush ten cycles into a DIV; result must keep the REMW value above.
    valid_in = 1'b1;
    op       = SEL_DIV;
    src_a    = 64'd1000;
    src_b    = 64'd3;
    tick();
    valid_in  = 1'b0;
    op        = SEL_NONE;
    done_seen = 1'b0;
    repeat (9) begin
      if (done) done_seen = 1'b1;
      tick();
    end
    flush = 1'b1;
    if (done) done_seen = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", 64'(busy), 64'd0);
    check("flush.no_done", 64'(done_seen | done), 64'd0);
    check("flush.result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("after_flush", SEL_DIVU, 64'd100, 64'd7, 64'd14, DIV_LAT);

    // flush in the same cycle as valid_in blocks the accept
    valid_in = 1'b1;
    flush    = 1'b1;
    op       = SEL_DIVU;
    src_a    = 64'd9;
    src_b    = 64'd0;
    #1;
    check("flush_valid.busy", 64'(busy), 64'd0);
    tick();
    valid_in = 1'b0;
    flush    = 1'b0;
    op       = SEL_NONE;
    check("flush_valid.idle", 64'({busy, done}), 64'd0);
    check("flush_valid.result", result, 64'd14);

    // reset mid-operation clears the result
    valid_in = 1'b1;
    op       = SEL_MUL;
    src_a    = 64'd6;
    src_b    = 64'd7;
    tick();
    valid_in = 1'b0;
    op       = SEL_NONE;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid.idle", 64'({busy, done}), 64'd0);
    check("reset_mid.result", result, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
